// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the five-stage core: load-use stalls, taken-branch flushes,
// data-memory wait freezes, stall/flush performance counters and a memory-wait watchdog.
module hazard_stall_ctrl #(
    parameter int REG_AW      = 5,
    parameter int LU_STALL_N  = 1,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_br_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              if_flush,
    output logic              idex_flush,
    output logic              exmem_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0]        LU_LOAD   = 2'(LU_STALL_N - 1);

    state_t            state;
    state_t            state_nxt;
    state_t            ret_state;
    state_t            ret_state_nxt;
    state_t            eff_state;
    logic [1:0]        lu_cnt;
    logic [1:0]        lu_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu_hit;

    assign lu_hit = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // A released memory wait resumes exactly as the state it interrupted.
    assign eff_state = (state == MEM_WAIT) ? ret_state : state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ret_state <= RUN;
            lu_cnt    <= 2'd0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_state_nxt;
            lu_cnt    <= lu_cnt_nxt;
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        if_flush      = 1'b0;
        idex_flush    = 1'b0;
        exmem_hold    = 1'b0;
        state_nxt     = RUN;
        ret_state_nxt = ret_state;
        lu_cnt_nxt    = lu_cnt;

        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if_flush   = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            state_nxt  = MEM_WAIT;
            if (state != MEM_WAIT) begin
                ret_state_nxt = state;
            end
        end else if (ex_br_taken) begin
            if_flush   = 1'b1;
            idex_flush = 1'b1;
        end else if (eff_state == LU_STALL) begin
            // The stall length is fixed by the counter, independent of lu_hit.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (lu_cnt > 2'd1) begin
                lu_cnt_nxt = lu_cnt - 2'd1;
                state_nxt  = LU_STALL;
            end
        end else if (lu_hit) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (LU_STALL_N > 1) begin
                lu_cnt_nxt = LU_LOAD;
                state_nxt  = LU_STALL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_busy) begin
            if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_cnt == WAIT_LAST) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (if_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
